psi_inv_stream: RTL and testbench

Sequential generator of inverse twiddle factors psi^-bitrev(i) mod q for the INTT datapath (n = 16, q = 65537, psi = 2, psi^-1 = 32769). It is the inverse-direction counterpart of the forward twiddle lookup. It does not perform a random-access lookup; it streams the 16 factors to the Gentleman-Sande butterfly controller over a valid/ready handshake, in ascending or descending index order. A constant n^-1 output is provided for final INTT scaling.

---
 rtl/psi_inv_stream.sv | 141 ++++++++++++++
 tb/tb_psi_inv_stream.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/psi_inv_stream.sv
// rtl/psi_inv_stream.sv - streams inverse twiddles psi^-bitrev(i) mod 65537 over valid/ready
// Value for k = bitrev(i) is 2^-k = q - 2^(16-k), since 2^16 = -1 mod q.
module psi_inv_stream #(
    parameter int LOGN = 4,
    parameter int W    = 17
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            desc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_value,
    output logic [LOGN-1:0] out_index,
    output logic            out_last,
    output logic            busy,
    output logic            done,
    output logic [W-1:0]    n_inv
);
    localparam int N = 1 << LOGN;
    localparam logic [LOGN:0]   BEATS   = (LOGN+1)'(N);
    localparam logic [LOGN:0]   LAST_NB = (LOGN+1)'(N - 1);
    localparam logic [LOGN-1:0] MAX_IDX = LOGN'(N - 1);
    localparam logic [W-1:0]    Q       = W'(65537);
    localparam logic [W-1:0]    ONE     = W'(1);
    localparam logic [LOGN:0]   SH      = (LOGN+1)'(16);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic            desc_q, desc_d;
    logic [LOGN-1:0] cnt_q, cnt_d;
    logic [LOGN:0]   beats_q, beats_d;
    logic            valid_q, valid_d;
    logic [W-1:0]    value_q, value_d;
    logic [LOGN-1:0] index_q, index_d;
    logic            last_q, last_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [LOGN-1:0] k;
    logic [W-1:0]    pow;
    logic [W-1:0]    val;
    logic            load;
    logic            accept;

    always_comb begin
        k = '0;
        for (int j = 0; j < LOGN; j++) begin
            k[j] = cnt_q[LOGN-1-j];
        end
        pow = ONE << (SH - {1'b0, k});
        val = (k == '0) ? ONE : (Q - pow);
    end

    assign accept = valid_q && out_ready;
    assign load   = (state_q == RUN) && (beats_q != BEATS) && (!valid_q || out_ready);

    always_comb begin
        state_d = state_q;
        desc_d  = desc_q;
        cnt_d   = cnt_q;
        beats_d = beats_q;
        valid_d = valid_q;
        value_d = value_q;
        index_d = index_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    desc_d  = desc;
                    cnt_d   = desc ? MAX_IDX : '0;
                    beats_d = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (accept && last_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end else if (load) begin
                    valid_d = 1'b1;
                    value_d = val;
                    index_d = cnt_q;
                    last_d  = (beats_q == LAST_NB);
                    beats_d = beats_q + 1'b1;
                    // saturate at the end index so the counter never wraps
                    if (desc_q) begin
                        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                    end else begin
                        if (cnt_q != MAX_IDX) cnt_d = cnt_q + 1'b1;
                    end
                end else if (accept) begin
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            desc_q  <= 1'b0;
            cnt_q   <= '0;
            beats_q <= '0;
            valid_q <= 1'b0;
            value_q <= '0;
            index_q <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            desc_q  <= desc_d;
            cnt_q   <= cnt_d;
            beats_q <= beats_d;
            valid_q <= valid_d;
            value_q <= value_d;
            index_q <= index_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out_valid = valid_q;
    assign out_value = value_q;
    assign out_index = index_q;
    assign out_last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign n_inv     = W'(61441);

endmodule

// File: tb/tb_psi_inv_stream.sv
// tb/tb_psi_inv_stream.sv - bench for psi_inv_stream: modular-arithmetic model plus directed vectors
module tb_psi_inv_stream;
    logic        clk = 1'b0;
    logic        rst_n, start, desc, out_ready;
    logic        out_valid, out_last, busy, done;
    logic [16:0] out_value, n_inv;
    logic [3:0]  out_index;

    int pass_cnt = 0;
    int total_cnt = 0;

    psi_inv_stream #(.LOGN(4), .W(17)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .desc(desc),
        .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
        .out_index(out_index), .out_last(out_last), .busy(busy), .done(done),
        .n_inv(n_inv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int bitrev4(input int i);
        int r = 0;
        for (int b = 0; b < 4; b++) if ((i >> b) & 1) r |= 1 << (3 - b);
        return r;
    endfunction

    function automatic longint modpow(input longint base, input int e);
        longint r = 1;
        for (int j = 0; j < e; j++) r = (r * base) % 65537;
        return r;
    endfunction

    function automatic longint inv_val(input int i);
        return modpow(32769, bitrev4(i));
    endfunction

    function automatic longint fwd_val(input int i);
        return modpow(2, bitrev4(i));
    endfunction

    // model state: expected remaining beat indices of the stream in flight
    int     mq[$];
    bit     m_busy = 0;
    bit     m_done = 0;
    bit     prev_stall = 0;
    logic [16:0] prev_val;
    logic [3:0]  prev_idx;
    logic        prev_last;
    int     obs_n = 0;
    int     obs_idx[16];
    longint obs_val[16];
    bit     obs_last[16];

    always @(negedge clk) begin
        chk("n_inv", n_inv, 61441);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        if (out_valid) begin
            if (mq.size() == 0) begin
                chk("valid_without_pending_beat", 1, 0);
            end else begin
                chk("beat_index", out_index, mq[0]);
                chk("beat_value", out_value, inv_val(mq[0]));
                chk("beat_last", out_last, mq.size() == 1);
                chk("product_is_one", (longint'(out_value) * fwd_val(out_index)) % 65537, 1);
            end
        end
        if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_value", out_value, prev_val);
            chk("stall_index", out_index, prev_idx);
            chk("stall_last", out_last, prev_last);
        end
        m_done = 0;
        if (!rst_n) begin
            m_busy = 0;
            mq.delete();
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1;
                for (int i = 0; i < 16; i++) mq.push_back(desc ? 15 - i : i);
            end
        end else if (out_valid && out_ready && mq.size() > 0) begin
            if (obs_n < 16) begin
                obs_idx[obs_n]  = out_index;
                obs_val[obs_n]  = out_value;
                obs_last[obs_n] = out_last;
            end
            obs_n++;
            void'(mq.pop_front());
            if (mq.size() == 0) begin
                m_busy = 0;
                m_done = 1;
            end
        end
        prev_stall = rst_n && out_valid && !out_ready;
        prev_val   = out_value;
        prev_idx   = out_index;
        prev_last  = out_last;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int maxc, input bit rnd, output int cyc);
        cyc = 0;
        while (!done && cyc < maxc) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            step();
            cyc++;
        end
        if (!done) chk("done_timeout", 0, 1);
        out_ready = 1'b1;
    endtask

    task automatic wait_beat(input int idx, input int maxc);
        int c = 0;
        while (!(out_valid && out_index == 4'(idx)) && c < maxc) begin
            step();
            c++;
        end
        if (c >= maxc) chk("beat_timeout", 0, 1);
    endtask

    task automatic pulse_start(input bit d);
        start = 1'b1;
        desc  = d;
        step();
        start = 1'b0;
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; start = 1'b0; desc = 1'b0; out_ready = 1'b1;
        step();
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_value", out_value, 0);
        chk("rst_index", out_index, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        step();

        chk("model_pin_i0", inv_val(0), 1);
        chk("model_pin_i1", inv_val(1), 65281);
        chk("model_pin_i3", inv_val(3), 65521);

        // ascending, ready held high
        obs_n = 0;
        pulse_start(1'b0);
        chk("lat_busy", busy, 1);
        chk("lat_valid_early", out_valid, 0);
        step();
        chk("lat_valid", out_valid, 1);
        chk("lat_index", out_index, 0);
        wait_done(100, 1'b0, cyc);
        chk("asc_consecutive", cyc, 16);
        chk("asc_beats", obs_n, 16);
        chk("asc_v0", obs_val[0], 1);
        chk("asc_v1", obs_val[1], 65281);
        chk("asc_v2", obs_val[2], 61441);
        chk("asc_v3", obs_val[3], 65521);
        chk("asc_v8", obs_val[8], 32769);
        chk("asc_v15", obs_val[15], 65535);
        chk("asc_last15", obs_last[15], 1);
        chk("asc_last14", obs_last[14], 0);
        step();
        chk("done_one_cycle", done, 0);

        // descending
        obs_n = 0;
        pulse_start(1'b1);
        wait_done(100, 1'b0, cyc);
        chk("desc_first_idx", obs_idx[0], 15);
        chk("desc_first_val", obs_val[0], 65535);
        chk("desc_last_val", obs_val[15], 1);
        chk("desc_last_idx", obs_idx[15], 0);
        chk("desc_last_flag", obs_last[15], 1);
        step();

        // random backpressure
        obs_n = 0;
        pulse_start(1'b0);
        wait_done(400, 1'b1, cyc);
        chk("stall_beats", obs_n, 16);
        for (int i = 0; i < 16; i++) chk("stall_order", obs_idx[i], i);
        step();

        // start mid-stream ignored, then start on the done cycle
        obs_n = 0;
        pulse_start(1'b0);
        wait_beat(5, 40);
        pulse_start(1'b1);
        wait_done(100, 1'b0, cyc);
        chk("mid_start_beats", obs_n, 16);
        chk("mid_start_idx15", obs_idx[15], 15);
        pulse_start(1'b0);
        chk("b2b_busy", busy, 1);
        chk("b2b_valid_early", out_valid, 0);
        step();
        chk("b2b_valid", out_valid, 1);
        chk("b2b_index", out_index, 0);
        wait_done(100, 1'b0, cyc);
        step();

        // reset in the middle of a stream
        pulse_start(1'b0);
        wait_beat(9, 40);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_value", out_value, 0);
        chk("mrst_index", out_index, 0);
        step();
        step();
        chk("mrst_no_resume", out_valid, 0);
        pulse_start(1'b0);
        step();
        chk("restart_valid", out_valid, 1);
        chk("restart_index", out_index, 0);
        wait_done(100, 1'b0, cyc);
        step();
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
